// File: rtl/rom_fetch_pkg.sv
// ROM fetch sequencer shared types and constants.
// State encoding, flash bank bit, address pad and default watchdog.
package rom_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_FILL,
    S_PARKED,
    S_ABORT
  } state_t;

  localparam int         FLASH_BANK_BIT = 20;
  localparam logic [3:0] ADDR_PAD       = 4'b0000;
  localparam int         DEF_TIMEOUT    = 255;

endpackage

// File: rtl/rom_fetch_sequencer.sv
// One-byte ROM buffer fed by a streaming flash read; stalls CPU on miss.
// Ports: clk/rst_n, rom_config, CPU req/wait/data, flash fc_* handshake.
module rom_fetch_sequencer
  import rom_fetch_pkg::*;
#(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rom_config,
  input  logic                 req_valid,
  input  logic [11:0]          req_addr,
  input  logic                 rom_cycle,
  output logic                 wait_out,
  output logic [7:0]           rom_data,
  output logic [ADDR_BITS-1:0] fc_addr,
  output logic                 fc_start_read,
  output logic                 fc_stall_read,
  output logic                 fc_stop_read,
  input  logic [7:0]           fc_data,
  input  logic                 fc_data_ready,
  input  logic                 fc_busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t state, nxt;

  logic            buf_valid;
  logic [11:0]     buf_addr;
  logic [7:0]      buf_data;
  logic [11:0]     stream_addr;
  logic            stream_ok;
  logic [WD_W-1:0] wd;
  logic [7:0]      cfg_q;
  logic            dr_q;

  logic hit, miss, rise, cfg_chg;
  logic latch, cap, rearm;
  logic [23:0] fa_raw;

  assign hit     = buf_valid && (req_addr == buf_addr);
  assign miss    = req_valid && !hit;
  assign rise    = fc_data_ready && !dr_q;
  assign cfg_chg = rom_config != cfg_q;

  assign wait_out = rom_cycle && req_valid && !hit;
  assign rom_data = buf_data;

  assign fa_raw = {rom_config[7:5], 1'b0, rom_config[3:0],
                   ADDR_PAD, stream_addr}
                | (24'd1 << FLASH_BANK_BIT);
  assign fc_addr = ADDR_BITS'(fa_raw);

  assign fc_start_read = state == S_ISSUE;
  assign fc_stall_read = state == S_PARKED;
  assign fc_stop_read  = (state == S_ABORT) && fc_busy;

  always_comb begin
    nxt   = state;
    latch = 1'b0;
    cap   = 1'b0;
    rearm = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (miss) begin
          nxt   = S_ISSUE;
          latch = 1'b1;
        end
      end
      S_ISSUE: nxt = S_FILL;
      S_FILL: begin
        // config change wins: the byte in flight is from the old bank
        if (cfg_chg) begin
          nxt = S_ABORT;
        end else if (rise) begin
          nxt = S_PARKED;
          cap = 1'b1;
        end else if (wd == WD_LAST) begin
          nxt = S_ABORT;
        end
      end
      S_PARKED: begin
        if (cfg_chg) begin
          nxt = S_ABORT;
        end else if (miss) begin
          if (req_addr == stream_addr && stream_ok) begin
            nxt   = S_FILL;
            rearm = 1'b1;
          end else begin
            nxt = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        if (!fc_busy) begin
          if (miss) begin
            nxt   = S_ISSUE;
            latch = 1'b1;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      stream_addr <= '0;
      stream_ok   <= 1'b1;
      wd          <= '0;
      cfg_q       <= '0;
      dr_q        <= 1'b0;
    end else begin
      dr_q <= fc_data_ready;
      if (cfg_chg) begin
        cfg_q     <= rom_config;
        buf_valid <= 1'b0;
      end
      if (latch) begin
        stream_addr <= req_addr;
        stream_ok   <= 1'b1;
      end
      if (cap) begin
        buf_valid   <= 1'b1;
        buf_addr    <= stream_addr;
        buf_data    <= fc_data;
        stream_addr <= stream_addr + 12'd1;
        // the flash stream does not continue from 0xFFF to 0x000
        if (&stream_addr) stream_ok <= 1'b0;
      end
      if (state == S_ISSUE || rearm) begin
        wd <= '0;
      end else if (state == S_FILL) begin
        wd <= wd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for rom_fetch_sequencer with a scripted flash side.
// Drives after each rising edge, checks with immediate assertions.
module tb_rom_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_config;
  logic        req_valid;
  logic [11:0] req_addr;
  logic        rom_cycle;
  logic        wait_out;
  logic [7:0]  rom_data;
  logic [23:0] fc_addr;
  logic        fc_start_read;
  logic        fc_stall_read;
  logic        fc_stop_read;
  logic [7:0]  fc_data;
  logic        fc_data_ready;
  logic        fc_busy;

  int checks = 0;
  int fails  = 0;
  int starts = 0;
  int overlap = 0;

  rom_fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_config   (rom_config),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .rom_cycle    (rom_cycle),
    .wait_out     (wait_out),
    .rom_data     (rom_data),
    .fc_addr      (fc_addr),
    .fc_start_read(fc_start_read),
    .fc_stall_read(fc_stall_read),
    .fc_stop_read (fc_stop_read),
    .fc_data      (fc_data),
    .fc_data_ready(fc_data_ready),
    .fc_busy      (fc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && fc_start_read === 1'b1) starts++;
    if ((32'(fc_start_read) + 32'(fc_stall_read)
         + 32'(fc_stop_read)) > 1) overlap++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic deliver(input logic [7:0] d);
    fc_data       = d;
    fc_data_ready = 1'b1;
    cyc();
    fc_data_ready = 1'b0;
    #1;
  endtask

  int n;
  logic wok;

  initial begin
    rst_n = 1'b0;
    rom_config = 8'h00;
    req_valid = 1'b1;
    req_addr = 12'h000;
    rom_cycle = 1'b1;
    fc_data = 8'h00;
    fc_data_ready = 1'b0;
    fc_busy = 1'b0;
    #12;
    chk("rst_start", fc_start_read, 1'b0);
    chk("rst_stop", fc_stop_read, 1'b0);
    chk("rst_stall", fc_stall_read, 1'b0);
    chk("rst_data", rom_data, 8'h00);
    chk("rst_wait_comb", wait_out, 1'b1);
    req_valid = 1'b0;
    #1;
    chk("rst_wait_idle", wait_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // cold miss
    req_valid = 1'b1;
    req_addr = 12'h123;
    #1;
    chk("cold_wait", wait_out, 1'b1);
    cyc();
    chk("cold_start", fc_start_read, 1'b1);
    chk("cold_addr", fc_addr, 24'h100123);
    fc_busy = 1'b1;
    cyc();
    chk("cold_start_1cyc", fc_start_read, 1'b0);
    chk("cold_fill_stall", fc_stall_read, 1'b0);
    cyc();
    cyc();
    chk("cold_wait_fill", wait_out, 1'b1);
    deliver(8'hA5);
    chk("cold_data", rom_data, 8'hA5);
    chk("cold_wait_lo", wait_out, 1'b0);
    chk("cold_parked", fc_stall_read, 1'b1);
    chk("cold_starts", starts, 1);

    // sequential
    req_addr = 12'h124;
    #1;
    chk("seq_wait", wait_out, 1'b1);
    cyc();
    chk("seq_stall_fall", fc_stall_read, 1'b0);
    chk("seq_no_start", fc_start_read, 1'b0);
    deliver(8'h5A);
    chk("seq_data", rom_data, 8'h5A);
    chk("seq_wait_lo", wait_out, 1'b0);
    chk("seq_starts", starts, 1);

    // random miss from PARKED at 0x125
    req_addr = 12'h800;
    cyc();
    chk("rnd_stop", fc_stop_read, 1'b1);
    chk("rnd_no_stall", fc_stall_read, 1'b0);
    cyc();
    chk("rnd_stop_hold", fc_stop_read, 1'b1);
    fc_busy = 1'b0;
    #1;
    chk("rnd_stop_drop", fc_stop_read, 1'b0);
    cyc();
    chk("rnd_start", fc_start_read, 1'b1);
    chk("rnd_addr", fc_addr, 24'h100800);
    fc_busy = 1'b1;
    cyc();
    deliver(8'h11);
    chk("rnd_data", rom_data, 8'h11);

    // wrap 0xFFF -> 0x000
    req_addr = 12'hFFF;
    cyc();
    fc_busy = 1'b0;
    cyc();
    chk("wrap_fff_addr", fc_addr, 24'h100FFF);
    fc_busy = 1'b1;
    cyc();
    deliver(8'h77);
    chk("wrap_fff_data", rom_data, 8'h77);
    req_addr = 12'h000;
    cyc();
    chk("wrap_stop", fc_stop_read, 1'b1);
    chk("wrap_no_stall", fc_stall_read, 1'b0);
    fc_busy = 1'b0;
    cyc();
    chk("wrap_start", fc_start_read, 1'b1);
    chk("wrap_addr", fc_addr, 24'h100000);
    fc_busy = 1'b1;
    cyc();
    deliver(8'h3C);
    chk("wrap_data", rom_data, 8'h3C);
    chk("wrap_wait_lo", wait_out, 1'b0);

    // watchdog timeout
    req_addr = 12'h200;
    cyc();
    fc_busy = 1'b0;
    cyc();
    chk("to_start", fc_start_read, 1'b1);
    fc_busy = 1'b1;
    n = 0;
    wok = 1'b1;
    while (fc_stop_read !== 1'b1 && n < 400) begin
      cyc();
      n++;
      if (wait_out !== 1'b1) wok = 1'b0;
    end
    chk("to_cycles", n, 256);
    chk("to_wait_high", wok, 1'b1);
    fc_busy = 1'b0;
    cyc();
    chk("to_retry_start", fc_start_read, 1'b1);
    chk("to_retry_addr", fc_addr, 24'h100200);
    fc_busy = 1'b1;
    cyc();
    deliver(8'h42);
    chk("to_data", rom_data, 8'h42);

    // config change while PARKED
    rom_config = 8'h01;
    #1;
    chk("cfg_hit_before", wait_out, 1'b0);
    cyc();
    chk("cfg_stop", fc_stop_read, 1'b1);
    chk("cfg_buf_inval", wait_out, 1'b1);
    fc_busy = 1'b0;
    cyc();
    chk("cfg_start", fc_start_read, 1'b1);
    chk("cfg_addr", fc_addr, 24'h110200);
    chk("cfg_bank", fc_addr[19:16], 4'h1);
    fc_busy = 1'b1;
    cyc();
    deliver(8'h99);
    chk("cfg_data", rom_data, 8'h99);
    chk("cfg_wait_lo", wait_out, 1'b0);

    chk("start_total", starts, 7);
    chk("excl_outputs", overlap, 0);

    // async reset mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", fc_stall_read, 1'b0);
    chk("arst_stop", fc_stop_read, 1'b0);
    chk("arst_data", rom_data, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
